// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control for the 16-bit-instruction, 8-bit-datapath CPU.
// Fetches each instruction as two byte reads, then steps it through execute, memory and writeback.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] instr,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        branch,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic [7:0]  rs2_data,
    output logic        rf_we,
    output logic [7:0]  wb_data,
    output logic [7:0]  pc,
    output logic        instr_done,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_HI,
        S_FETCH_LO,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  alu_q, alu_d;
    logic [7:0]  mdr_q, mdr_d;
    logic [7:0]  sdr_q, sdr_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic        m2r_q, m2r_d;
    logic        br_q, br_d;
    logic        rf_we_c;
    logic        done_c;
    logic        no_flags;

    assign no_flags = ~(reg_write | mem_read | mem_write | mem_to_reg | branch);

    // State and datapath registers; reset wins over any pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            alu_q   <= 8'h00;
            mdr_q   <= 8'h00;
            sdr_q   <= 8'h00;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            sdr_q   <= sdr_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            m2r_q   <= m2r_d;
            br_q    <= br_d;
        end
    end

    // Next-state, register updates and memory-port drive per state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        sdr_d     = sdr_q;
        mr_d      = mr_q;
        mw_d      = mw_q;
        m2r_d     = m2r_q;
        br_d      = br_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        rf_we_c   = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH_HI;
            S_FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    instr_d[15:8] = mem_rdata;
                    state_d       = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + 8'd1;
                if (mem_ready) begin
                    instr_d[7:0] = mem_rdata;
                    pc_d         = pc_q + 8'd2;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                mr_d  = mem_read;
                mw_d  = mem_write;
                m2r_d = mem_to_reg;
                br_d  = branch;
                if (instr_q[15:12] == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else if ((mem_read & mem_write) | no_flags) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH_HI;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_d = alu_result;
                sdr_d = rs2_data;
                if (mr_q | mw_q) begin
                    state_d = S_MEM;
                end else if (br_q) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH_HI;
                    if (alu_zero) pc_d = pc_q + instr_q[7:0];
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = alu_q;
                mem_we    = ~mr_q;
                mem_wdata = mr_q ? 8'h00 : sdr_q;
                if (mem_ready) begin
                    if (mr_q) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WRITEBACK;
                    end else begin
                        done_c  = 1'b1;
                        state_d = S_FETCH_HI;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we_c = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH_HI;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are suppressed in a cycle that is being reset away.
    assign rf_we      = rf_we_c & ~rst;
    assign instr_done = done_c & ~rst;
    assign halted     = (state_q == S_HALT);
    assign wb_data    = m2r_q ? mdr_q : alu_q;
    assign pc         = pc_q;
    assign instr      = instr_q;

endmodule
